// File: rtl/je_frame_seq.sv
// Frame sequencer: arms a camera capture, runs je_ip, reads back the sized JPEG
// stream at a paced rate and hands it to the host over valid/ready.
module je_frame_seq #(
   parameter int unsigned RD_GAP      = 8,
   parameter int unsigned MAX_BYTES   = 131072,
   parameter int unsigned TIMEOUT_CYC = 16777215
) (
   input  logic        pclk,
   input  logic        reset_n,
   input  logic        img_req,
   input  logic        cam_vsync,
   output logic        pixel_wr_disable,
   output logic        conv_start,
   input  logic        conv_end,
   input  logic [7:0]  enc_data,
   output logic        enc_rd,
   output logic [7:0]  host_data,
   output logic        host_valid,
   input  logic        host_ready,
   output logic [31:0] jpeg_size,
   output logic        busy,
   output logic        frame_done,
   output logic        err_size,
   output logic        err_no_eoi,
   output logic        err_timeout
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ARM     = 3'd1,
      S_CAPTURE = 3'd2,
      S_ENCODE  = 3'd3,
      S_HDR     = 3'd4,
      S_STREAM  = 3'd5,
      S_DONE    = 3'd6
   } state_t;

   localparam logic [7:0]  GAP_RELOAD = 8'(RD_GAP - 1);
   localparam logic [23:0] TMO_LAST   = 24'(TIMEOUT_CYC - 1);
   localparam logic [31:0] SIZE_MAX   = 32'(MAX_BYTES);
   localparam logic [15:0] EOI_MARK   = 16'hFFD9;

   state_t      state_q, state_d;
   logic        pwd_q, pwd_d, conv_start_q, conv_start_d, enc_rd_q, enc_rd_d;
   logic [7:0]  host_data_q, host_data_d;
   logic        host_valid_q, host_valid_d, busy_q, busy_d, frame_done_q, frame_done_d;
   logic [31:0] jpeg_size_q, jpeg_size_d, byte_cnt_q, byte_cnt_d;
   logic        err_size_q, err_size_d, err_no_eoi_q, err_no_eoi_d, err_timeout_q, err_timeout_d;
   logic [7:0]  gap_q, gap_d;
   logic [23:0] tmo_q, tmo_d;
   logic [2:0]  hdr_cnt_q, hdr_cnt_d;
   logic [15:0] eoi_q, eoi_d;

   logic        accept_s, abort_s, rd_ok_s;
   logic [31:0] size_nxt_s;

   assign accept_s   = host_valid_q & host_ready;
   assign size_nxt_s = {jpeg_size_q[23:0], enc_data};
   assign abort_s    = ~img_req & (state_q != S_IDLE) & (state_q != S_DONE);
   // A stream read needs the pacing gap expired and room in the host register
   assign rd_ok_s    = (gap_q == 8'd0) & ~enc_rd_q & (~host_valid_q | accept_s)
                     & (byte_cnt_q < jpeg_size_q) & (eoi_q != EOI_MARK);

   always_comb begin
      state_d       = state_q;
      pwd_d         = pwd_q;
      conv_start_d  = conv_start_q;
      enc_rd_d      = 1'b0;
      host_data_d   = host_data_q;
      host_valid_d  = host_valid_q;
      frame_done_d  = 1'b0;
      jpeg_size_d   = jpeg_size_q;
      byte_cnt_d    = byte_cnt_q;
      err_size_d    = err_size_q;
      err_no_eoi_d  = err_no_eoi_q;
      err_timeout_d = err_timeout_q;
      gap_d         = (gap_q != 8'd0) ? (gap_q - 8'd1) : 8'd0;
      tmo_d         = tmo_q;
      hdr_cnt_d     = hdr_cnt_q;
      eoi_d         = eoi_q;

      if (abort_s) begin
         state_d      = S_IDLE;
         conv_start_d = 1'b0;
         host_valid_d = 1'b0;
         pwd_d        = 1'b1;
      end else begin
         case (state_q)
            S_IDLE: begin
               pwd_d        = 1'b1;
               conv_start_d = 1'b0;
               host_valid_d = 1'b0;
               if (img_req) begin
                  err_size_d    = 1'b0;
                  err_no_eoi_d  = 1'b0;
                  err_timeout_d = 1'b0;
                  state_d       = S_ARM;
               end else begin
                  state_d = S_IDLE;
               end
            end
            S_ARM: begin
               if (cam_vsync) begin
                  pwd_d   = 1'b0;
                  state_d = S_CAPTURE;
               end else begin
                  pwd_d = 1'b1;
               end
            end
            S_CAPTURE: begin
               if (cam_vsync) begin
                  pwd_d        = 1'b1;
                  conv_start_d = 1'b1;
                  tmo_d        = 24'd0;
                  state_d      = S_ENCODE;
               end else begin
                  pwd_d = 1'b0;
               end
            end
            S_ENCODE: begin
               if (conv_end) begin
                  hdr_cnt_d = 3'd0;
                  state_d   = S_HDR;
               end else if (tmo_q == TMO_LAST) begin
                  err_timeout_d = 1'b1;
                  conv_start_d  = 1'b0;
                  frame_done_d  = 1'b1;
                  state_d       = S_DONE;
               end else begin
                  tmo_d = tmo_q + 24'd1;
               end
            end
            S_HDR: begin
               // hdr_cnt_q counts issued reads, so it reads 4 while the last byte returns
               if (enc_rd_q) begin
                  jpeg_size_d = size_nxt_s;
                  if (hdr_cnt_q == 3'd4) begin
                     if ((size_nxt_s == 32'd0) || (size_nxt_s > SIZE_MAX)) begin
                        err_size_d   = 1'b1;
                        conv_start_d = 1'b0;
                        frame_done_d = 1'b1;
                        state_d      = S_DONE;
                     end else begin
                        byte_cnt_d = 32'd0;
                        eoi_d      = 16'd0;
                        state_d    = S_STREAM;
                     end
                  end else begin
                     state_d = S_HDR;
                  end
               end else if ((gap_q == 8'd0) && (hdr_cnt_q < 3'd4)) begin
                  enc_rd_d  = 1'b1;
                  gap_d     = GAP_RELOAD;
                  hdr_cnt_d = hdr_cnt_q + 3'd1;
               end else begin
                  state_d = S_HDR;
               end
            end
            S_STREAM: begin
               if (enc_rd_q) begin
                  host_data_d  = enc_data;
                  host_valid_d = 1'b1;
                  byte_cnt_d   = (byte_cnt_q == 32'hFFFF_FFFF) ? byte_cnt_q : (byte_cnt_q + 32'd1);
                  eoi_d        = {eoi_q[7:0], enc_data};
               end else if (accept_s) begin
                  host_valid_d = 1'b0;
                  if (eoi_q == EOI_MARK) begin
                     conv_start_d = 1'b0;
                     frame_done_d = 1'b1;
                     state_d      = S_DONE;
                  end else if (byte_cnt_q == jpeg_size_q) begin
                     err_no_eoi_d = 1'b1;
                     conv_start_d = 1'b0;
                     frame_done_d = 1'b1;
                     state_d      = S_DONE;
                  end else begin
                     state_d = S_STREAM;
                  end
               end else begin
                  state_d = S_STREAM;
               end
               if (rd_ok_s) begin
                  enc_rd_d = 1'b1;
                  gap_d    = GAP_RELOAD;
               end else begin
                  enc_rd_d = 1'b0;
               end
            end
            S_DONE: begin
               pwd_d        = 1'b1;
               conv_start_d = 1'b0;
               host_valid_d = 1'b0;
               if (!img_req) begin
                  state_d = S_IDLE;
               end else begin
                  state_d = S_DONE;
               end
            end
            default: begin
               state_d      = S_IDLE;
               pwd_d        = 1'b1;
               conv_start_d = 1'b0;
               host_valid_d = 1'b0;
            end
         endcase
      end
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge pclk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= S_IDLE;
         pwd_q         <= 1'b1;
         conv_start_q  <= 1'b0;
         enc_rd_q      <= 1'b0;
         host_data_q   <= 8'd0;
         host_valid_q  <= 1'b0;
         busy_q        <= 1'b0;
         frame_done_q  <= 1'b0;
         jpeg_size_q   <= 32'd0;
         byte_cnt_q    <= 32'd0;
         err_size_q    <= 1'b0;
         err_no_eoi_q  <= 1'b0;
         err_timeout_q <= 1'b0;
         gap_q         <= 8'd0;
         tmo_q         <= 24'd0;
         hdr_cnt_q     <= 3'd0;
         eoi_q         <= 16'd0;
      end else begin
         state_q       <= state_d;
         pwd_q         <= pwd_d;
         conv_start_q  <= conv_start_d;
         enc_rd_q      <= enc_rd_d;
         host_data_q   <= host_data_d;
         host_valid_q  <= host_valid_d;
         busy_q        <= busy_d;
         frame_done_q  <= frame_done_d;
         jpeg_size_q   <= jpeg_size_d;
         byte_cnt_q    <= byte_cnt_d;
         err_size_q    <= err_size_d;
         err_no_eoi_q  <= err_no_eoi_d;
         err_timeout_q <= err_timeout_d;
         gap_q         <= gap_d;
         tmo_q         <= tmo_d;
         hdr_cnt_q     <= hdr_cnt_d;
         eoi_q         <= eoi_d;
      end
   end

   assign pixel_wr_disable = pwd_q;
   assign conv_start       = conv_start_q;
   assign enc_rd           = enc_rd_q;
   assign host_data        = host_data_q;
   assign host_valid       = host_valid_q;
   assign jpeg_size        = jpeg_size_q;
   assign busy             = busy_q;
   assign frame_done       = frame_done_q;
   assign err_size         = err_size_q;
   assign err_no_eoi       = err_no_eoi_q;
   assign err_timeout      = err_timeout_q;

endmodule

// File: tb/tb_je_frame_seq.sv
// Bench for je_frame_seq: cycle table for capture gating plus directed frames
// against a small je_ip byte-source model and a host-side receive monitor.
module tb_je_frame_seq;

   logic        pclk = 1'b0;
   logic        reset_n, img_req, cam_vsync, conv_end, host_ready;
   logic        pixel_wr_disable, conv_start, enc_rd, host_valid, busy, frame_done;
   logic        err_size, err_no_eoi, err_timeout;
   logic [7:0]  enc_data, host_data;
   logic [31:0] jpeg_size;

   je_frame_seq #(.RD_GAP(8), .MAX_BYTES(131072), .TIMEOUT_CYC(100)) dut (
      .pclk(pclk), .reset_n(reset_n), .img_req(img_req), .cam_vsync(cam_vsync),
      .pixel_wr_disable(pixel_wr_disable), .conv_start(conv_start), .conv_end(conv_end),
      .enc_data(enc_data), .enc_rd(enc_rd), .host_data(host_data), .host_valid(host_valid),
      .host_ready(host_ready), .jpeg_size(jpeg_size), .busy(busy), .frame_done(frame_done),
      .err_size(err_size), .err_no_eoi(err_no_eoi), .err_timeout(err_timeout)
   );

   typedef struct {
      logic req;
      logic vs;
      logic exp_pwd;
      logic exp_cs;
      logic exp_busy;
   } vec_t;

   vec_t       tbl [0:12];
   logic [7:0] enc_mem [0:63];
   logic [5:0] enc_ptr = 6'd0;
   logic       ptr_clr = 1'b0;
   int         cyc = 0;
   int         total = 0;
   int         bad = 0;
   int         fd_cnt = 0;
   int         hold_viol = 0;
   logic       hold_pend = 1'b0;
   logic [7:0] hold_data = 8'd0;
   logic [7:0] rx_q [$];
   int         rd_cyc [$];

   assign enc_data = enc_mem[enc_ptr];

   always #5 pclk = ~pclk;

   always @(posedge pclk) cyc <= cyc + 1;

   always @(posedge pclk) begin
      if (ptr_clr) enc_ptr <= 6'd0;
      else if (enc_rd) enc_ptr <= enc_ptr + 6'd1;
   end

   // Sample just before each rising edge: inputs and outputs are both settled
   always begin
      @(negedge pclk);
      #3;
      if (host_valid && host_ready) rx_q.push_back(host_data);
      if (enc_rd) rd_cyc.push_back(cyc);
      if (frame_done) fd_cnt <= fd_cnt + 1;
      if (hold_pend && !(host_valid && host_data == hold_data)) hold_viol <= hold_viol + 1;
      hold_pend <= host_valid && !host_ready;
      hold_data <= host_data;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(negedge pclk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic load_frame(input logic [31:0] hdr, input int n, input bit with_eoi);
      enc_mem[0] = hdr[31:24];
      enc_mem[1] = hdr[23:16];
      enc_mem[2] = hdr[15:8];
      enc_mem[3] = hdr[7:0];
      for (int i = 0; i < 60; i++) enc_mem[4 + i] = (i < n) ? (8'h10 + 8'(i)) : 8'h00;
      if (with_eoi) begin
         enc_mem[7]         = 8'hFF;
         enc_mem[4 + n - 2] = 8'hFF;
         enc_mem[4 + n - 1] = 8'hD9;
      end
      ptr_clr = 1'b1;
      tick();
      ptr_clr = 1'b0;
   endtask

   task automatic to_encode();
      img_req = 1'b1;
      tick(); tick();
      cam_vsync = 1'b1; tick(); cam_vsync = 1'b0;
      tick(); tick(); tick();
      cam_vsync = 1'b1; tick(); cam_vsync = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int limit);
      int w = 0;
      while (frame_done !== 1'b1 && w < limit) begin
         tick();
         w++;
      end
      check({tag, "_done_seen"}, 32'(frame_done), 32'd1);
   endtask

   task automatic finish_frame(input string tag);
      conv_end   = 1'b0;
      host_ready = 1'b1;
      img_req    = 1'b0;
      tick(); tick();
      check({tag, "_idle_busy"}, 32'(busy), 32'd0);
   endtask

   task automatic cmp_rx(input string tag, input int base, input int n);
      int mism = 0;
      check({tag, "_rx_count"}, 32'(rx_q.size() - base), 32'(n));
      for (int i = 0; i < n; i++)
         if (base + i >= rx_q.size() || rx_q[base + i] !== enc_mem[4 + i]) mism++;
      check({tag, "_rx_bytes"}, 32'(mism), 32'd0);
   endtask

   task automatic nominal(input string tag);
      int rxb, rdb, fdb, bad_gap;
      load_frame(32'h0000_1234, 10, 1'b1);
      rxb = rx_q.size(); rdb = rd_cyc.size(); fdb = fd_cnt;
      host_ready = 1'b1;
      to_encode();
      tick(); tick();
      conv_end = 1'b1;
      wait_done(tag, 400);
      check({tag, "_errs"}, 32'({err_size, err_no_eoi, err_timeout}), 32'd0);
      tick(); tick();
      check({tag, "_jpeg_size"}, jpeg_size, 32'h0000_1234);
      cmp_rx(tag, rxb, 10);
      check({tag, "_rd_count"}, 32'(rd_cyc.size() - rdb), 32'd14);
      bad_gap = 0;
      for (int i = rdb + 1; i < rd_cyc.size(); i++)
         if (rd_cyc[i] - rd_cyc[i - 1] != 8) bad_gap++;
      check({tag, "_rd_spacing"}, 32'(bad_gap), 32'd0);
      check({tag, "_done_pulses"}, 32'(fd_cnt - fdb), 32'd1);
      finish_frame(tag);
   endtask

   initial begin
      int rxb, rdb, fdb, hvb, w;
      logic [7:0] hd0;

      tbl[0]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      tbl[2]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      tbl[6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      tbl[7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      tbl[8]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
      tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      tbl[11] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      tbl[12] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

      reset_n = 1'b0; img_req = 1'b0; cam_vsync = 1'b0; conv_end = 1'b0; host_ready = 1'b1;
      for (int i = 0; i < 64; i++) enc_mem[i] = 8'h00;
      tick(); tick();
      check("reset_flags", 32'({pixel_wr_disable, conv_start, enc_rd, host_valid, busy,
                                frame_done, err_size, err_no_eoi, err_timeout}), 32'h100);
      check("reset_data", 32'(jpeg_size) | 32'(host_data), 32'd0);
      reset_n = 1'b1;
      tick();

      for (int i = 0; i < 13; i++) begin
         img_req   = tbl[i].req;
         cam_vsync = tbl[i].vs;
         tick();
         check($sformatf("tbl_row%0d", i),
               32'({pixel_wr_disable, conv_start, busy, frame_done, enc_rd, host_valid}),
               32'({tbl[i].exp_pwd, tbl[i].exp_cs, tbl[i].exp_busy, 3'b000}));
      end
      img_req = 1'b0; cam_vsync = 1'b0;
      tick();

      nominal("nom");

      // Backpressure: hold host_ready low for 50 cycles with a byte pending
      load_frame(32'h0000_0020, 12, 1'b1);
      rxb = rx_q.size();
      to_encode();
      tick(); tick();
      conv_end = 1'b1;
      w = 0;
      while (!((rx_q.size() - rxb >= 4) && host_valid) && w < 300) begin tick(); w++; end
      check("bp_reach_mid", 32'(host_valid), 32'd1);
      host_ready = 1'b0;
      hd0 = host_data; rdb = rd_cyc.size(); hvb = hold_viol;
      for (int i = 0; i < 50; i++) tick();
      check("bp_no_rd", 32'(rd_cyc.size() - rdb), 32'd0);
      check("bp_data_held", 32'({host_valid, host_data}), 32'({1'b1, hd0}));
      check("bp_hold_viol", 32'(hold_viol - hvb), 32'd0);
      host_ready = 1'b1;
      wait_done("bp", 300);
      tick(); tick();
      cmp_rx("bp", rxb, 12);
      check("bp_errs", 32'({err_size, err_no_eoi, err_timeout}), 32'd0);
      finish_frame("bp");

      // Oversized header
      load_frame(32'h0002_0001, 0, 1'b0);
      rxb = rx_q.size(); fdb = fd_cnt;
      to_encode();
      tick(); tick();
      conv_end = 1'b1;
      wait_done("sz", 200);
      check("sz_err_size", 32'({err_size, err_no_eoi, err_timeout}), 32'b100);
      check("sz_outputs", 32'({conv_start, host_valid, busy}), 32'b001);
      tick(); tick();
      check("sz_jpeg_size", jpeg_size, 32'h0002_0001);
      check("sz_rx_none", 32'(rx_q.size() - rxb), 32'd0);
      check("sz_done_pulses", 32'(fd_cnt - fdb), 32'd1);
      finish_frame("sz");

      // Size reached without EOI
      load_frame(32'h0000_0010, 16, 1'b0);
      rxb = rx_q.size(); rdb = rd_cyc.size();
      to_encode();
      check("ne_err_cleared", 32'(err_size), 32'd0);
      tick(); tick();
      conv_end = 1'b1;
      wait_done("ne", 400);
      check("ne_err_no_eoi", 32'({err_size, err_no_eoi, err_timeout}), 32'b010);
      tick(); tick();
      cmp_rx("ne", rxb, 16);
      check("ne_rd_count", 32'(rd_cyc.size() - rdb), 32'd20);
      finish_frame("ne");
      check("ne_sticky", 32'(err_no_eoi), 32'd1);

      // conv_end withheld: timeout 100 cycles after ENCODE entry
      load_frame(32'h0000_0010, 4, 1'b0);
      to_encode();
      check("to_cs_rise", 32'(conv_start), 32'd1);
      w = 0;
      while (err_timeout !== 1'b1 && w < 150) begin tick(); w++; end
      check("to_cycles", 32'(w), 32'd100);
      check("to_done_cs", 32'({frame_done, conv_start, err_no_eoi}), 32'b100);
      finish_frame("to");

      // Abort mid-stream, then a clean rerun
      load_frame(32'h0000_0030, 20, 1'b0);
      rxb = rx_q.size();
      to_encode();
      check("ab_err_cleared", 32'({err_size, err_no_eoi, err_timeout}), 32'd0);
      tick(); tick();
      conv_end = 1'b1;
      w = 0;
      while ((rx_q.size() - rxb < 3) && w < 300) begin tick(); w++; end
      check("ab_reach_stream", 32'(rx_q.size() - rxb >= 3), 32'd1);
      fdb = fd_cnt;
      img_req = 1'b0;
      tick();
      check("ab_outputs", 32'({busy, conv_start, host_valid, pixel_wr_disable}), 32'b0001);
      tick(); tick(); tick();
      check("ab_no_done", 32'(fd_cnt - fdb), 32'd0);
      check("ab_stay_idle", 32'({busy, enc_rd}), 32'd0);
      conv_end = 1'b0;
      tick();
      nominal("rerun");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/je_frame_seq.md
Name: je_frame_seq

Overview:
Frame sequencer sitting between the host (ESP32 SPI bridge), the camera pixel writer and je_ip. It arms capture on host request and freezes SPRAM writes after one full frame. It then starts je_ip, reads back the 4-byte big-endian size header and JPEG byte stream at a paced rate, and forwards the bytes to the host over a valid/ready interface. It terminates on the EOI marker and flags size, EOI and timeout errors.

Parameters:
RD_GAP, 8, minimum pclk cycles between successive enc_rd pulses (2..255)
MAX_BYTES, 131072, largest legal jpeg_size; larger values raise err_size
TIMEOUT_CYC, 16777215, pclk cycles allowed in ENCODE before err_timeout (24-bit counter)

Ports:
pclk  in  1  clock
reset_n  in  1  asynchronous, active-low reset
img_req  in  1  host frame request, level; deassertion aborts
cam_vsync  in  1  camera frame-start, single-cycle pulse
pixel_wr_disable  out  1  1 = camera writes to SPRAM blocked
conv_start  out  1  level start to je_ip
conv_end  in  1  je_ip output ready (level)
enc_data  in  8  je_ip data_out, valid in the cycle enc_rd=1
enc_rd  out  1  single-cycle read strobe to je_ip
host_data  out  8  JPEG byte to host
host_valid  out  1  host_data valid
host_ready  in  1  host accepts byte when host_valid & host_ready
jpeg_size  out  32  captured header value
busy  out  1  state != IDLE
frame_done  out  1  one-cycle pulse on entry to DONE
err_size  out  1  sticky until next arm: header 0 or > MAX_BYTES
err_no_eoi  out  1  sticky: jpeg_size bytes sent without FFD9
err_timeout  out  1  sticky: conv_end not seen within TIMEOUT_CYC

Behaviour:
- Reset: pixel_wr_disable=1, all other outputs 0, state IDLE, counters cleared.
- IDLE: pixel_wr_disable=1. On img_req=1: clear all err_* flags, go ARM.
- ARM: pixel_wr_disable=1. On cam_vsync: go CAPTURE, pixel_wr_disable=0 from the next cycle.
- CAPTURE: on the next cam_vsync: pixel_wr_disable=1 from the next cycle, go ENCODE.
- ENCODE: conv_start=1, timeout counter increments per cycle. conv_end=1 -> HDR. Counter == TIMEOUT_CYC-1 without conv_end -> err_timeout=1, go DONE.
- conv_start=1 in ENCODE, HDR and STREAM only.
- Pacing: gap counter reloads RD_GAP-1 on each enc_rd. The next enc_rd may issue only when the counter is 0.
- HDR: issues 4 enc_rd pulses and samples jpeg_size <= {jpeg_size[23:0], enc_data} on each. After the 4th pulse: size 0 or > MAX_BYTES -> err_size=1, DONE; otherwise STREAM.
- STREAM: enc_rd may issue when the gap counter is 0 and the output register is empty or being accepted in the same cycle. Simultaneous accept and refill is allowed, giving back-to-back bytes with no bubble.
- STREAM, per read byte: enc_data loads host_data, host_valid=1, byte count increments (17-bit+ saturating), and eoi_reg <= {eoi_reg[7:0], enc_data}.
- host_data and host_valid hold stable until accepted.
- STREAM exit: once eoi_reg==16'hFFD9 and the last byte is accepted -> DONE. Else if byte count == jpeg_size and the last byte is accepted -> err_no_eoi=1, DONE. EOI takes precedence if both hold on the same byte.
- DONE: frame_done pulses on the entry cycle; conv_start=0, host_valid=0. Waits for img_req=0, then returns to IDLE.
- Abort: img_req=0 in ARM/CAPTURE/ENCODE/HDR/STREAM -> IDLE next cycle. On abort: conv_start=0, host_valid=0, pixel_wr_disable=1, no frame_done, err flags keep their values.
- cam_vsync in ENCODE/HDR/STREAM/DONE is ignored.
- conv_end dropping during STREAM is ignored; the block relies on the byte count and EOI.

Test Plan:
- Nominal: header 00 00 12 34, stream ending FF D9, host_ready=1 -> jpeg_size=0x1234; bytes forwarded in order; enc_rd spacing exactly 8 cycles; frame_done 1 pulse; err_*=0.
- Capture gating: vsync pulses at t0, t1 -> pixel_wr_disable=0 only in cycles t0+1..t1; conv_start rises the cycle after the 2nd vsync.
- Backpressure: host_ready=0 for 50 cycles mid-stream -> host_data stable, no enc_rd, no byte lost or duplicated.
- Header 0x00020001 (> MAX_BYTES) -> err_size=1, zero host bytes, frame_done pulse.
- 16 bytes, jpeg_size=16, no FFD9 -> err_no_eoi=1 after 16th accept; conv_end withheld instead (TIMEOUT_CYC=100) -> err_timeout at cycle 100.
- img_req dropped mid-STREAM -> IDLE next cycle, conv_start=0, host_valid=0, no frame_done; re-request clears err flags and runs cleanly.
